adc_data_qualifier: RTL and testbench



---
 rtl/adc_data_qualifier.sv | 213 +++++++++++++++++++++
 tb/tb_adc_data_qualifier.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_data_qualifier.sv
// adc_data_qualifier: shutdown and zero-sample gating between the ADC FIFO
// read side and the PID pipeline, in the pid_clk domain.
//
// Per channel: 2-FF synchroniser and debounce FSM on shutdown_in,
// zero-run rejection with a global run limit, a 2-bit mode register
// ({zero_reject_en, kill_en}), and a saturating drop counter.
//
// Ports:
//   clk_in, rst_in          pid_clk, synchronous active-high reset
//   shutdown_in             asynchronous per-channel kill lines
//   dv_in/chan_in/data_in   input sample stream (no backpressure)
//   wr_en/wr_addr/wr_chan/wr_data  configuration write bus
//   rd_chan_in              drop counter read select
//   dv_out/chan_out/data_out       qualified sample stream, 1-cycle latency
//   kill_state_out          debounced kill state per channel
//   drop_cnt_out            drop count of rd_chan_in, registered
module adc_data_qualifier #(
  parameter int unsigned N_CHAN    = 8,
  parameter int unsigned W_CHAN    = 3,
  parameter int unsigned W_DATA    = 18,
  parameter int unsigned W_DEB     = 8,
  parameter int unsigned W_CNT     = 16,
  parameter int unsigned W_WR_ADDR = 4,
  parameter int unsigned W_WR_CHAN = 4,
  parameter int unsigned W_WR_DATA = 16,
  parameter int unsigned MODE_ADDR = 'hA,
  parameter int unsigned DEB_ADDR  = 'hB,
  parameter int unsigned ZLIM_ADDR = 'hC,
  parameter int unsigned CLR_ADDR  = 'hD
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [N_CHAN-1:0]    shutdown_in,
  input  logic                 dv_in,
  input  logic [W_CHAN-1:0]    chan_in,
  input  logic [W_DATA-1:0]    data_in,
  input  logic                 wr_en,
  input  logic [W_WR_ADDR-1:0] wr_addr,
  input  logic [W_WR_CHAN-1:0] wr_chan,
  input  logic [W_WR_DATA-1:0] wr_data,
  input  logic [W_CHAN-1:0]    rd_chan_in,
  output logic                 dv_out,
  output logic [W_CHAN-1:0]    chan_out,
  output logic [W_DATA-1:0]    data_out,
  output logic [N_CHAN-1:0]    kill_state_out,
  output logic [W_CNT-1:0]     drop_cnt_out
);

  typedef enum logic {
    ARMED   = 1'b0,
    PENDING = 1'b1
  } deb_state_e;

  // Global configuration
  logic [W_DEB-1:0]     deb_len;
  logic [W_WR_DATA-1:0] zero_lim;

  logic wr_mode;
  logic wr_deb;
  logic wr_zlim;
  logic wr_clr;
  logic is_zero;

  logic [N_CHAN-1:0] drop_vec;
  logic [W_CNT-1:0]  cnt_arr [N_CHAN];
  logic [W_CNT-1:0]  rd_sel;

  assign wr_mode = wr_en && (wr_addr == W_WR_ADDR'(MODE_ADDR));
  assign wr_deb  = wr_en && (wr_addr == W_WR_ADDR'(DEB_ADDR));
  assign wr_zlim = wr_en && (wr_addr == W_WR_ADDR'(ZLIM_ADDR));
  assign wr_clr  = wr_en && (wr_addr == W_WR_ADDR'(CLR_ADDR));
  assign is_zero = (data_in == '0);

  // Global config registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      deb_len  <= '0;
      zero_lim <= '0;
    end else begin
      if (wr_deb)  deb_len  <= wr_data[W_DEB-1:0];
      if (wr_zlim) zero_lim <= wr_data;
    end
  end

  // Per-channel qualification; out-of-range chan_in/wr_chan match no channel
  for (genvar c = 0; c < N_CHAN; c++) begin : g_chan
    logic                 hit;
    logic                 wr_sel;
    logic                 clr;
    logic [1:0]           mode;
    logic                 sync_meta;
    logic                 sync;
    deb_state_e           state_q;
    deb_state_e           state_d;
    logic [W_DEB-1:0]     deb_cnt_q;
    logic [W_DEB-1:0]     deb_cnt_d;
    logic                 kill_q;
    logic                 kill_d;
    logic [W_WR_DATA-1:0] zrun;
    logic [W_CNT-1:0]     drop_cnt;
    logic                 kill_drop;
    logic                 zero_drop;

    assign hit    = dv_in && (chan_in == W_CHAN'(c));
    assign wr_sel = (wr_chan == W_WR_CHAN'(c));
    assign clr    = wr_clr && (wr_data[0] || wr_sel);

    assign kill_drop = mode[0] && kill_q;
    assign zero_drop = mode[1] && is_zero && ((zero_lim == '0) || (zrun < zero_lim));
    assign drop_vec[c] = hit && (kill_drop || zero_drop);

    assign kill_state_out[c] = kill_q;
    assign cnt_arr[c]        = drop_cnt;

    // Synchroniser and debounce state register
    always_ff @(posedge clk_in) begin
      if (rst_in) begin
        sync_meta <= 1'b0;
        sync      <= 1'b0;
        state_q   <= ARMED;
        deb_cnt_q <= '0;
        kill_q    <= 1'b0;
      end else begin
        sync_meta <= shutdown_in[c];
        sync      <= sync_meta;
        state_q   <= state_d;
        deb_cnt_q <= deb_cnt_d;
        kill_q    <= kill_d;
      end
    end

    // Debounce next state: the entry cycle counts as the first count, so
    // kill flips deb_len cycles after the mismatch is first seen.
    always_comb begin
      state_d   = state_q;
      deb_cnt_d = deb_cnt_q;
      kill_d    = kill_q;
      case (state_q)
        ARMED: begin
          if (sync != kill_q) begin
            if (deb_len == '0) begin
              kill_d = sync;
            end else begin
              state_d   = PENDING;
              deb_cnt_d = W_DEB'(1);
            end
          end
        end
        PENDING: begin
          if (sync == kill_q) begin
            state_d   = ARMED;
            deb_cnt_d = '0;
          end else if (deb_cnt_q >= deb_len) begin
            // >= so a shortened deb_len flips on the next cycle
            state_d   = ARMED;
            deb_cnt_d = '0;
            kill_d    = ~kill_q;
          end else begin
            deb_cnt_d = deb_cnt_q + W_DEB'(1);
          end
        end
        default: begin
          state_d   = ARMED;
          deb_cnt_d = '0;
        end
      endcase
    end

    // Mode, zero-run and drop counter registers
    always_ff @(posedge clk_in) begin
      if (rst_in) begin
        mode     <= 2'b11;
        zrun     <= '0;
        drop_cnt <= '0;
      end else begin
        if (wr_mode && wr_sel) mode <= wr_data[1:0];
        if (hit) begin
          if (!is_zero)        zrun <= '0;
          else if (zrun != '1) zrun <= zrun + W_WR_DATA'(1);
        end
        // Clear has priority over a same-cycle increment
        if (clr)                                drop_cnt <= '0;
        else if (drop_vec[c] && drop_cnt != '1) drop_cnt <= drop_cnt + W_CNT'(1);
      end
    end
  end

  // Drop counter read mux; unmatched select reads zero
  always_comb begin
    rd_sel = '0;
    for (int c = 0; c < N_CHAN; c++) begin
      if (rd_chan_in == W_CHAN'(c)) rd_sel = cnt_arr[c];
    end
  end

  // Output stage
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      dv_out       <= 1'b0;
      chan_out     <= '0;
      data_out     <= '0;
      drop_cnt_out <= '0;
    end else begin
      dv_out <= dv_in && !(|drop_vec);
      if (dv_in) begin
        chan_out <= chan_in;
        data_out <= data_in;
      end
      drop_cnt_out <= rd_sel;
    end
  end

endmodule

// File: tb/tb_adc_data_qualifier.sv
// Testbench for adc_data_qualifier: table-driven sample vectors with a
// scoreboard for the output stream, plus hand-written debounce, counter
// and reset sequences. Instantiated with a 4-bit drop counter.
module tb_adc_data_qualifier;

  localparam logic [3:0] A_MODE = 4'hA;
  localparam logic [3:0] A_DEB  = 4'hB;
  localparam logic [3:0] A_ZLIM = 4'hC;
  localparam logic [3:0] A_CLR  = 4'hD;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [7:0]  shutdown_in;
  logic        dv_in;
  logic [2:0]  chan_in;
  logic [17:0] data_in;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [3:0]  wr_chan;
  logic [15:0] wr_data;
  logic [2:0]  rd_chan_in;
  logic        dv_out;
  logic [2:0]  chan_out;
  logic [17:0] data_out;
  logic [7:0]  kill_state_out;
  logic [3:0]  drop_cnt_out;

  adc_data_qualifier #(.W_CNT(4)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .shutdown_in    (shutdown_in),
    .dv_in          (dv_in),
    .chan_in        (chan_in),
    .data_in        (data_in),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_chan        (wr_chan),
    .wr_data        (wr_data),
    .rd_chan_in     (rd_chan_in),
    .dv_out         (dv_out),
    .chan_out       (chan_out),
    .data_out       (data_out),
    .kill_state_out (kill_state_out),
    .drop_cnt_out   (drop_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int          grp;
    logic [2:0]  chan;
    logic [17:0] data;
    bit          pass;
  } vec_t;

  typedef struct {
    logic [2:0]  chan;
    logic [17:0] data;
    int          cyc;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   k_exp;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Output monitor: every dv_out must match the oldest expected sample,
  // exactly one cycle after it was driven.
  always @(negedge clk_in) begin
    if (dv_out === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL out_unexpected: got chan %0d data %0d at cycle %0d, required no output",
                 chan_out, data_out, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (chan_out !== mon_e.chan || data_out !== mon_e.data || cyc != mon_e.cyc + 1) begin
          n_err++;
          $display("FAIL out_sample: got chan %0d data %0d cycle %0d, required chan %0d data %0d cycle %0d",
                   chan_out, data_out, cyc, mon_e.chan, mon_e.data, mon_e.cyc + 1);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit dv, input logic [2:0] ch, input logic [17:0] d, input bit pass,
                       input bit we, input logic [3:0] a, input logic [3:0] wc, input logic [15:0] wd);
    @(negedge clk_in);
    dv_in   = dv;
    chan_in = ch;
    data_in = d;
    wr_en   = we;
    wr_addr = a;
    wr_chan = wc;
    wr_data = wd;
    if (dv && pass) exp_q.push_back('{ch, d, cyc});
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 18'd0, 1'b0, 1'b0, 4'd0, 4'd0, 16'd0);
  endtask

  task automatic sample(input logic [2:0] ch, input logic [17:0] d, input bit pass);
    drive(1'b1, ch, d, pass, 1'b0, 4'd0, 4'd0, 16'd0);
  endtask

  task automatic cfg(input logic [3:0] a, input logic [3:0] wc, input logic [15:0] wd);
    drive(1'b0, 3'd0, 18'd0, 1'b0, 1'b1, a, wc, wd);
    idle();
  endtask

  // Two cycles: one for a pending count update, one for the read register
  task automatic check_cnt(input logic [2:0] ch, input int exp);
    rd_chan_in = ch;
    idle();
    idle();
    chk($sformatf("drop_cnt[%0d]", ch), 32'(drop_cnt_out), 32'(exp));
  endtask

  task automatic run_grp(input int g);
    foreach (tbl[i]) begin
      if (tbl[i].grp == g) sample(tbl[i].chan, tbl[i].data, tbl[i].pass);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_in      = 1'b1;
    shutdown_in = '0;
    dv_in       = 1'b0;
    chan_in     = '0;
    data_in     = '0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_chan     = '0;
    wr_data     = '0;
    rd_chan_in  = '0;

    // grp 1: defaults, zero rejected; grp 2/3: zero_lim=3 on ch1; grp 4: ch3 mode 00
    tbl.push_back('{1, 3'd0, 18'd1,      1'b1});
    tbl.push_back('{1, 3'd6, 18'h3FFFF,  1'b1});
    tbl.push_back('{1, 3'd2, 18'd5,      1'b1});
    tbl.push_back('{1, 3'd2, 18'd0,      1'b0});
    tbl.push_back('{1, 3'd2, 18'd7,      1'b1});
    tbl.push_back('{2, 3'd1, 18'd0,      1'b0});
    tbl.push_back('{2, 3'd1, 18'd0,      1'b0});
    tbl.push_back('{2, 3'd1, 18'd0,      1'b0});
    tbl.push_back('{2, 3'd1, 18'd0,      1'b1});
    tbl.push_back('{2, 3'd1, 18'd0,      1'b1});
    tbl.push_back('{3, 3'd1, 18'd9,      1'b1});
    tbl.push_back('{3, 3'd1, 18'd0,      1'b0});
    tbl.push_back('{4, 3'd3, 18'd0,      1'b1});
    tbl.push_back('{4, 3'd3, 18'd0,      1'b1});
    tbl.push_back('{4, 3'd3, 18'd0,      1'b1});
    tbl.push_back('{4, 3'd3, 18'd5,      1'b1});

    // Reset values
    repeat (3) idle();
    chk("rst_dv_out",   32'(dv_out),         32'd0);
    chk("rst_chan_out", 32'(chan_out),       32'd0);
    chk("rst_data_out", 32'(data_out),       32'd0);
    chk("rst_kill",     32'(kill_state_out), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt_out),   32'd0);
    rst_in = 1'b0;
    idle();

    // Default zero rejection
    run_grp(1);
    check_cnt(3'd2, 1);
    chk("hold_chan_out", 32'(chan_out), 32'd2);
    chk("hold_data_out", 32'(data_out), 32'd7);

    // Zero-run limit
    cfg(A_ZLIM, 4'd0, 16'd3);
    run_grp(2);
    check_cnt(3'd1, 3);
    run_grp(3);
    check_cnt(3'd1, 4);
    chk("drop_loads_chan_out", 32'(chan_out), 32'd1);
    chk("drop_loads_data_out", 32'(data_out), 32'd0);

    // Mode 00 passes killed zero samples
    cfg(A_MODE, 4'd3, 16'd0);
    shutdown_in[3] = 1'b1;
    repeat (4) idle();
    chk("kill3_set", 32'(kill_state_out), 32'h08);
    run_grp(4);
    check_cnt(3'd3, 0);
    shutdown_in[3] = 1'b0;
    repeat (4) idle();
    chk("kill3_clear", 32'(kill_state_out), 32'h00);

    // Debounce deb_len=4: rise and fall 7 cycles after the input edge
    cfg(A_DEB, 4'd0, 16'd4);
    shutdown_in[0] = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      k_exp = (i >= 7 && i <= 12) ? 1 : 0;
      sample(3'd0, 18'(200 + i), (k_exp == 0));
      chk($sformatf("kill0_deb4_c%0d", i), 32'(kill_state_out[0]), 32'(k_exp));
      if (i == 6) shutdown_in[0] = 1'b0;
    end

    // 3-cycle glitch is filtered
    shutdown_in[0] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      idle();
      if (i == 3) shutdown_in[0] = 1'b0;
      chk($sformatf("kill0_glitch_c%0d", i), 32'(kill_state_out[0]), 32'd0);
    end

    // deb_len shortened below a running count flips on the next cycle
    cfg(A_DEB, 4'd0, 16'd20);
    shutdown_in[0] = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      if (i == 8) drive(1'b0, 3'd0, 18'd0, 1'b0, 1'b1, A_DEB, 4'd0, 16'd2);
      else        idle();
      chk($sformatf("kill0_debwr_c%0d", i), 32'(kill_state_out[0]), 32'((i >= 10) ? 1 : 0));
    end
    shutdown_in[0] = 1'b0;
    repeat (8) idle();
    chk("kill0_debwr_release", 32'(kill_state_out[0]), 32'd0);
    cfg(A_DEB, 4'd0, 16'd0);

    // Drop counter saturation and clears
    cfg(A_ZLIM, 4'd0, 16'd0);
    repeat (20) sample(3'd4, 18'd0, 1'b0);
    check_cnt(3'd4, 15);
    drive(1'b1, 3'd4, 18'd0, 1'b0, 1'b1, A_CLR, 4'd4, 16'd0);
    check_cnt(3'd4, 0);
    check_cnt(3'd2, 1);
    repeat (2) sample(3'd4, 18'd0, 1'b0);
    check_cnt(3'd4, 2);
    cfg(A_CLR, 4'd4, 16'd0);
    check_cnt(3'd4, 0);
    check_cnt(3'd1, 4);
    sample(3'd4, 18'd0, 1'b0);
    cfg(A_CLR, 4'd0, 16'd1);
    check_cnt(3'd1, 0);
    check_cnt(3'd2, 0);
    check_cnt(3'd4, 0);

    // Reset while streaming with a debounce pending
    cfg(A_DEB, 4'd0, 16'd6);
    shutdown_in[5] = 1'b1;
    sample(3'd2, 18'd0, 1'b0);
    for (int i = 2; i <= 5; i++) sample(3'd6, 18'(300 + i), 1'b1);
    sample(3'd6, 18'd399, 1'b0);
    rst_in = 1'b1;
    sample(3'd5, 18'd0, 1'b0);
    chk("midrst_dv_out",   32'(dv_out),         32'd0);
    chk("midrst_kill",     32'(kill_state_out), 32'd0);
    chk("midrst_chan_out", 32'(chan_out),       32'd0);
    chk("midrst_data_out", 32'(data_out),       32'd0);
    chk("midrst_drop_cnt", 32'(drop_cnt_out),   32'd0);
    idle();
    rst_in = 1'b0;
    idle();
    idle();
    chk("postrst_kill5_early", 32'(kill_state_out[5]), 32'd0);
    idle();
    chk("postrst_kill5_deb0", 32'(kill_state_out[5]), 32'd1);
    check_cnt(3'd5, 0);
    check_cnt(3'd2, 0);
    sample(3'd5, 18'd9, 1'b0);
    check_cnt(3'd5, 1);
    shutdown_in[5] = 1'b0;
    repeat (6) idle();
    chk("postrst_kill5_release", 32'(kill_state_out[5]), 32'd0);

    repeat (3) idle();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
